// File: rtl/if_pc_gen_btb.sv
`default_nettype none
// ============================================================================
// Module   : if_pc_gen_btb
// Purpose  : Instruction-fetch PC generator with a direct-mapped branch
//            target buffer (BTB). Selects the next fetch PC from the
//            mispredict redirect, a stall hold, a predicted-taken BTB
//            target, or the sequential PC+4. It also carries the IF/ID
//            PC+4 and prediction bit, and trains the BTB from branches
//            resolved in ID.
// Ports    : clk                    - single clock, posedge
//            rst_n                  - asynchronous active-low reset
//            i_br_prediction        - direction predictor output for IF
//            i_branch_hazard_stall  - hold PC and IF/ID capture
//            i_flush                - mispredict of the branch in ID
//            i_id_is_branch         - instruction in ID is a cond. branch
//            i_id_branch_target     - resolved target of the ID branch
//            o_pc_IF                - fetch address
//            o_pc_plus4_IF          - o_pc_IF + 4 (mod 2^32)
//            o_pc_plus4_ID          - PC+4 of the instruction in ID
//            o_pred_taken_ID        - taken-prediction of the ID instruction
//            o_btb_hit_IF           - valid BTB tag match on o_pc_IF
//            o_squash_IF            - clear IF/ID this cycle (== i_flush)
// Revision : 1.0 - initial release
// ============================================================================
module if_pc_gen_btb #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BTB_ENTRIES = 16            // power of two, 2..256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_br_prediction,
  input  logic        i_branch_hazard_stall,
  input  logic        i_flush,
  input  logic        i_id_is_branch,
  input  logic [31:0] i_id_branch_target,
  output logic [31:0] o_pc_IF,
  output logic [31:0] o_pc_plus4_IF,
  output logic [31:0] o_pc_plus4_ID,
  output logic        o_pred_taken_ID,
  output logic        o_btb_hit_IF,
  output logic        o_squash_IF
);

  localparam int c_IDX  = $clog2(BTB_ENTRIES);
  localparam int c_TAGW = 30 - c_IDX;

  // BTB storage: only the valid bits are reset; tag/target are qualified by valid.
  logic [BTB_ENTRIES-1:0] r_btb_valid;
  logic [c_TAGW-1:0]      r_btb_tag [BTB_ENTRIES];
  logic [31:0]            r_btb_tgt [BTB_ENTRIES];

  logic [31:0] r_pc;
  logic [31:0] r_pc_plus4_ID;
  logic        r_pred_taken_ID;

  logic [31:0]       w_pc_plus4;
  logic [c_IDX-1:0]  w_lk_idx;
  logic [c_TAGW-1:0] w_lk_tag;
  logic              w_btb_hit;
  logic              w_pred_taken_IF;
  logic [31:0]       w_redirect_pc;
  logic [31:0]       w_next_pc;
  logic [29:0]       w_wr_word;
  logic [c_IDX-1:0]  w_wr_idx;
  logic [c_TAGW-1:0] w_wr_tag;
  logic              w_actual_taken;
  logic              w_btb_we;

  assign w_pc_plus4 = r_pc + 32'd4;

  // Combinational lookup; reads pre-write contents when a write hits the same index.
  assign w_lk_idx        = r_pc[c_IDX+1:2];
  assign w_lk_tag        = r_pc[31:c_IDX+2];
  assign w_btb_hit       = r_btb_valid[w_lk_idx] && (r_btb_tag[w_lk_idx] == w_lk_tag);
  assign w_pred_taken_IF = i_br_prediction & w_btb_hit;

  // A predicted-taken branch that mispredicted falls through to its PC+4;
  // a predicted-not-taken one goes to its resolved target.
  assign w_redirect_pc = r_pred_taken_ID ? r_pc_plus4_ID : i_id_branch_target;

  always_comb begin
    w_next_pc = w_pc_plus4;
    if (i_flush)                    w_next_pc = w_redirect_pc;
    else if (i_branch_hazard_stall) w_next_pc = r_pc;
    else if (w_pred_taken_IF)       w_next_pc = r_btb_tgt[w_lk_idx];
  end

  // Branch PC of the ID instruction, in word units (PC+4 minus one word).
  assign w_wr_word = r_pc_plus4_ID[31:2] - 30'd1;
  assign w_wr_idx  = w_wr_word[c_IDX-1:0];
  assign w_wr_tag  = w_wr_word[29:c_IDX];

  // A flush means the prediction was wrong, so the real outcome is its inverse.
  // Flush overrides a coincident stall for training as well.
  assign w_actual_taken = r_pred_taken_ID ^ i_flush;
  assign w_btb_we       = i_id_is_branch && (i_flush || !i_branch_hazard_stall) && w_actual_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc            <= RESET_PC;
      r_pc_plus4_ID   <= RESET_PC;
      r_pred_taken_ID <= 1'b0;
    end else begin
      r_pc <= w_next_pc;
      if (i_flush) begin
        r_pc_plus4_ID   <= w_redirect_pc;
        r_pred_taken_ID <= 1'b0;
      end else if (!i_branch_hazard_stall) begin
        r_pc_plus4_ID   <= w_pc_plus4;
        r_pred_taken_ID <= w_pred_taken_IF;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btb_valid <= '0;
    end else if (w_btb_we) begin
      r_btb_valid[w_wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_btb_we) begin
      r_btb_tag[w_wr_idx] <= w_wr_tag;
      r_btb_tgt[w_wr_idx] <= i_id_branch_target;
    end
  end

  assign o_pc_IF         = r_pc;
  assign o_pc_plus4_IF   = w_pc_plus4;
  assign o_pc_plus4_ID   = r_pc_plus4_ID;
  assign o_pred_taken_ID = r_pred_taken_ID;
  assign o_btb_hit_IF    = w_btb_hit;
  assign o_squash_IF     = i_flush;

endmodule
`default_nettype wire

// File: tb/tb_if_pc_gen_btb.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_pc_gen_btb
// Purpose  : Self-checking bench for if_pc_gen_btb: directed vector table,
//            a mid-stream asynchronous reset sequence, then randomized
//            traffic checked against a behavioural fetch/BTB model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_pc_gen_btb;

  localparam int c_N = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_br_prediction = 1'b0;
  logic        i_branch_hazard_stall = 1'b0;
  logic        i_flush = 1'b0;
  logic        i_id_is_branch = 1'b0;
  logic [31:0] i_id_branch_target = 32'h0;
  logic [31:0] o_pc_IF, o_pc_plus4_IF, o_pc_plus4_ID;
  logic        o_pred_taken_ID, o_btb_hit_IF, o_squash_IF;

  int n_cmp = 0;
  int n_fail = 0;

  // Behavioural model: each BTB slot remembers the full branch address.
  logic [31:0] m_pc, m_pc4_id;
  logic        m_pid;
  bit          m_val [c_N];
  logic [31:0] m_bpc [c_N];
  logic [31:0] m_tgt [c_N];

  if_pc_gen_btb #(.RESET_PC(32'h0), .BTB_ENTRIES(c_N)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .i_br_prediction       (i_br_prediction),
    .i_branch_hazard_stall (i_branch_hazard_stall),
    .i_flush               (i_flush),
    .i_id_is_branch        (i_id_is_branch),
    .i_id_branch_target    (i_id_branch_target),
    .o_pc_IF               (o_pc_IF),
    .o_pc_plus4_IF         (o_pc_plus4_IF),
    .o_pc_plus4_ID         (o_pc_plus4_ID),
    .o_pred_taken_ID       (o_pred_taken_ID),
    .o_btb_hit_IF          (o_btb_hit_IF),
    .o_squash_IF           (o_squash_IF)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int slot(input logic [31:0] a);
    return int'((a >> 2) % 32'(c_N));
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return m_val[slot(a)] && ((m_bpc[slot(a)] >> 2) == (a >> 2));
  endfunction

  task automatic m_reset();
    m_pc = 32'h0; m_pc4_id = 32'h0; m_pid = 1'b0;
    for (int i = 0; i < c_N; i++) m_val[i] = 1'b0;
  endtask

  // Drive inputs at the falling edge and compare all outputs against the model.
  task automatic drive_check(input logic p, input logic s, input logic f,
                             input logic b, input logic [31:0] t);
    @(negedge clk);
    i_br_prediction = p; i_branch_hazard_stall = s; i_flush = f;
    i_id_is_branch = b; i_id_branch_target = t;
    #1;
    chk("m_pc_IF",         o_pc_IF,         m_pc);
    chk("m_pc_plus4_IF",   o_pc_plus4_IF,   m_pc + 32'd4);
    chk("m_pc_plus4_ID",   o_pc_plus4_ID,   m_pc4_id);
    chk("m_pred_taken_ID", 32'(o_pred_taken_ID), 32'(m_pid));
    chk("m_btb_hit_IF",    32'(o_btb_hit_IF),    32'(m_hit(m_pc)));
    chk("m_squash_IF",     32'(o_squash_IF),     32'(f));
  endtask

  // Compute what the fetch unit does at the coming edge, then commit it there.
  task automatic advance();
    logic [31:0] npc, npc4, redirect, bpc;
    logic        npid, pt;
    pt       = i_br_prediction && m_hit(m_pc);
    redirect = m_pid ? m_pc4_id : i_id_branch_target;
    npc4 = m_pc4_id; npid = m_pid;
    if (i_flush) begin
      npc = redirect; npc4 = redirect; npid = 1'b0;
    end else if (i_branch_hazard_stall) begin
      npc = m_pc;
    end else begin
      npc  = pt ? m_tgt[slot(m_pc)] : m_pc + 32'd4;
      npc4 = m_pc + 32'd4; npid = pt;
    end
    @(posedge clk);
    // Resolved taken branch trains the BTB at this edge.
    if (i_id_is_branch && (i_flush || !i_branch_hazard_stall) && (m_pid != i_flush)) begin
      bpc = m_pc4_id - 32'd4;
      m_val[slot(bpc)] = 1'b1;
      m_bpc[slot(bpc)] = bpc;
      m_tgt[slot(bpc)] = i_id_branch_target;
    end
    m_pc = npc; m_pc4_id = npc4; m_pid = npid;
  endtask

  typedef struct {
    logic        p, s, f, b;
    logic [31:0] t;
    logic [31:0] e_pc, e_pc4id;
    logic        e_pid, e_hit;
  } vec_t;

  vec_t vt [20];

  initial begin
    logic [31:0] t;
    // inputs: pred stall flush isbr target | expected pc_IF pc_plus4_ID pred_ID hit
    vt[0]  = '{0,0,0,0,32'h00, 32'h00,32'h00,0,0};
    vt[1]  = '{0,0,0,0,32'h00, 32'h04,32'h04,0,0};
    vt[2]  = '{0,0,0,0,32'h00, 32'h08,32'h08,0,0};
    vt[3]  = '{0,0,0,0,32'h00, 32'h0C,32'h0C,0,0};
    vt[4]  = '{0,0,0,0,32'h00, 32'h10,32'h10,0,0};
    vt[5]  = '{0,0,1,1,32'h40, 32'h14,32'h14,0,0}; // branch @0x10 resolves taken
    vt[6]  = '{0,0,1,0,32'h10, 32'h40,32'h40,0,0}; // steer back to 0x10
    vt[7]  = '{1,0,0,0,32'h00, 32'h10,32'h10,0,1}; // hit, predicted taken
    vt[8]  = '{0,0,1,1,32'h40, 32'h40,32'h14,1,0}; // resolves not taken
    vt[9]  = '{0,0,1,0,32'h10, 32'h14,32'h14,0,0};
    vt[10] = '{0,0,0,0,32'h00, 32'h10,32'h10,0,1}; // entry still present
    vt[11] = '{0,0,0,0,32'h00, 32'h14,32'h14,0,0};
    vt[12] = '{0,0,0,0,32'h00, 32'h18,32'h18,0,0};
    vt[13] = '{0,0,0,0,32'h00, 32'h1C,32'h1C,0,0};
    vt[14] = '{0,1,0,0,32'h00, 32'h20,32'h20,0,0}; // stall x2
    vt[15] = '{0,1,0,0,32'h00, 32'h20,32'h20,0,0};
    vt[16] = '{0,0,0,0,32'h00, 32'h20,32'h20,0,0};
    vt[17] = '{0,1,1,1,32'h80, 32'h24,32'h24,0,0}; // flush beats stall
    vt[18] = '{0,0,1,0,32'h20, 32'h80,32'h80,0,0};
    vt[19] = '{1,0,1,0,32'h5C, 32'h20,32'h20,0,1}; // flush beats prediction

    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pc_IF",         o_pc_IF,         32'h0);
    chk("rst_pc_plus4_ID",   o_pc_plus4_ID,   32'h0);
    chk("rst_pred_taken_ID", 32'(o_pred_taken_ID), 32'h0);
    chk("rst_btb_hit_IF",    32'(o_btb_hit_IF),    32'h0);
    chk("rst_squash_IF",     32'(o_squash_IF),     32'h0);
    @(posedge clk); #2 rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      drive_check(vt[i].p, vt[i].s, vt[i].f, vt[i].b, vt[i].t);
      chk($sformatf("vec%0d_pc_IF", i),       o_pc_IF,       vt[i].e_pc);
      chk($sformatf("vec%0d_pc_plus4_ID", i), o_pc_plus4_ID, vt[i].e_pc4id);
      chk($sformatf("vec%0d_pred_ID", i),     32'(o_pred_taken_ID), 32'(vt[i].e_pid));
      chk($sformatf("vec%0d_hit", i),         32'(o_btb_hit_IF),    32'(vt[i].e_hit));
      advance();
    end

    // Asynchronous reset pulse mid-cycle at pc 0x5C.
    @(negedge clk);
    i_br_prediction = 0; i_branch_hazard_stall = 0; i_flush = 0; i_id_is_branch = 0;
    #1 chk("pre_rst_pc_IF", o_pc_IF, 32'h5C);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_pc_IF",       o_pc_IF,       32'h0);
    chk("async_rst_pc_plus4_ID", o_pc_plus4_ID, 32'h0);
    chk("async_rst_pred_ID",     32'(o_pred_taken_ID), 32'h0);
    m_reset();
    @(posedge clk); #2 rst_n = 1'b1;
    drive_check(0, 0, 0, 0, 32'h0);
    chk("post_rst_pc0", o_pc_IF, 32'h0);
    advance();
    drive_check(0, 0, 1, 0, 32'h20);
    chk("post_rst_pc4", o_pc_IF, 32'h4);
    advance();
    drive_check(1, 0, 0, 0, 32'h0);
    chk("post_rst_pc20", o_pc_IF, 32'h20);
    chk("post_rst_miss", 32'(o_btb_hit_IF), 32'h0);
    advance();

    // Randomized traffic against the model.
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 3) != 0) t = 32'($urandom_range(0, 63)) << 2;
      else                           t = $urandom & 32'hFFFF_FFFC;
      drive_check($urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 4) < 2, t);
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/if_pc_gen_btb.md
IF_PC_GEN_BTB -- requirements
Module: if_pc_gen_btb

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter BTB_ENTRIES, default 16, BTB depth; SHALL be a power of two, 2..256; IDX = log2(BTB_ENTRIES).
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 br_prediction  input  1  2-bit predictor direction for the instruction currently in IF.
REQ-006 branch_hazard_stall  input  1  hold PC and the IF/ID capture this cycle.
REQ-007 flush  input  1  mispredict of the branch currently in ID.
REQ-008 id_is_branch  input  1  instruction in ID is a conditional branch (opcode 000100).
REQ-009 id_branch_target  input  32  resolved target of the ID branch (pc_plus4_ID + sign-extended imm<<2).
REQ-010 pc_IF  output  32  instruction-memory fetch address.
REQ-011 pc_plus4_IF  output  32  pc_IF + 4, wrapping modulo 2^32.
REQ-012 pc_plus4_ID  output  32  registered pc_plus4_IF of the instruction now in ID.
REQ-013 pred_taken_ID  output  1  registered taken-prediction of the instruction now in ID.
REQ-014 btb_hit_IF  output  1  valid BTB entry whose tag matches pc_IF.
REQ-015 squash_IF  output  1  clear the IF/ID register this cycle; equals flush.

Function
REQ-016 BTB SHALL be direct-mapped: index = pc[IDX+1:2], tag = pc[31:IDX+2]; entries hold valid, tag and 32-bit target.
REQ-017 BTB lookup SHALL be combinational on pc_IF; pred_taken_IF = br_prediction & btb_hit_IF.
REQ-018 Next-PC priority, evaluated each cycle: (1) flush -> redirect_pc; (2) else branch_hazard_stall -> hold pc_IF; (3) else pred_taken_IF -> BTB target; (4) else pc_plus4_IF.
REQ-019 redirect_pc SHALL be pc_plus4_ID when pred_taken_ID=1, else id_branch_target.
REQ-020 On no-stall, no-flush cycles, pc_plus4_ID <= pc_plus4_IF and pred_taken_ID <= pred_taken_IF.
REQ-021 During a stall without flush, pc_plus4_ID and pred_taken_ID SHALL hold.
REQ-022 On flush, pred_taken_ID <= 0 and pc_plus4_ID <= redirect_pc (bubble carries no prediction).
REQ-023 Actual outcome of the ID branch SHALL be derived as pred_taken_ID XOR flush, valid only when id_is_branch=1 and branch_hazard_stall=0.
REQ-024 When the actual outcome is taken, the BTB entry indexed by (pc_plus4_ID - 4) SHALL be written at the clock edge: valid=1, tag from that PC, target=id_branch_target.
REQ-025 A not-taken outcome SHALL leave the BTB unchanged; no invalidation.
REQ-026 Same-cycle lookup and write to the same index: lookup returns pre-write contents; the new entry is visible from the next cycle.
REQ-027 flush and branch_hazard_stall both high: flush wins for PC, ID registers and BTB write.
REQ-028 Latency: a BTB write is visible one cycle later; a redirect appears on pc_IF one cycle after flush is asserted.

Reset
REQ-029 While rst_n=0: pc_IF=RESET_PC, pc_plus4_ID=RESET_PC, pred_taken_ID=0, all BTB valid bits cleared; tags and targets unreset.
REQ-030 Assertion mid-operation SHALL take effect immediately regardless of clk; first fetch after deassertion is RESET_PC.
REQ-031 btb_hit_IF and squash_IF SHALL be 0 during and directly after reset, unless flush is driven.

Verification
REQ-032 Reset, then 4 idle cycles -> pc_IF 0x0, 0x4, 0x8, 0xC; btb_hit_IF=0 throughout.
REQ-033 Branch at 0x10 reaches ID with pred_taken_ID=0, flush=1, target 0x40 -> next pc_IF=0x40; BTB[4] valid with target 0x40; a later fetch of 0x10 with br_prediction=1 -> next pc_IF=0x40.
REQ-034 pc_IF=0x10, BTB hit, br_prediction=1, then ID resolves not-taken (flush=1) -> next pc_IF=0x14, pred_taken_ID=0, BTB entry unchanged.
REQ-035 branch_hazard_stall=1 for 2 cycles at pc_IF=0x20 -> pc_IF, pc_plus4_ID and pred_taken_ID hold; resumes at 0x24.
REQ-036 flush=1 and branch_hazard_stall=1 together, pred_taken_ID=0, target 0x80 -> pc_IF=0x80; squash_IF=1.
REQ-037 rst_n low for half a cycle mid-stream at pc_IF=0x5C -> pc_IF=0x0 at once; prior BTB hits miss after deassertion.
